balance_ledger: RTL

Account balance register that consumes the single-cycle transaction pulses produced by the transaction front-ends. Each pulse is one fixed-denomination unit: a withdraw pulse (count_down) debits the balance and a deposit pulse (count_up) credits it. Every request is checked against available funds, a per-day withdrawal limit and a balance ceiling. The block reports completion or denial, with a reason code, to the display/status logic.

---
 rtl/balance_ledger.sv | 102 ++++++++++
 1 files changed

// File: rtl/balance_ledger.sv
// Account balance register: debits/credits one UNIT per request pulse,
// enforcing available funds, a daily withdrawal limit and a balance ceiling.
module balance_ledger #(
  parameter int BW       = 16,
  parameter int UNIT     = 100,
  parameter int INIT_BAL = 1000,
  parameter int MAX_BAL  = 50000,
  parameter int MAX_WD   = 5,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          count_down,
  input  logic          count_up,
  input  logic          day_clr,
  output logic [BW-1:0] balance,
  output logic          done,
  output logic          denied,
  output logic [1:0]    reason,
  output logic          busy,
  output logic [CW-1:0] wd_count
);

  typedef enum logic [1:0] {
    IDLE,
    DEBIT,
    CREDIT,
    DENY
  } state_t;

  localparam logic [BW-1:0] UNIT_W   = BW'(UNIT);
  localparam logic [BW-1:0] INIT_W   = BW'(INIT_BAL);
  localparam logic [BW:0]   MAX_W    = (BW+1)'(MAX_BAL);
  localparam logic [CW-1:0] MAX_WD_W = CW'(MAX_WD);

  localparam logic [1:0] R_NONE  = 2'b00;
  localparam logic [1:0] R_FUNDS = 2'b01;
  localparam logic [1:0] R_LIMIT = 2'b10;
  localparam logic [1:0] R_CEIL  = 2'b11;

  state_t        state, state_n;
  logic [BW-1:0] bal_n;
  logic [CW-1:0] wd_n;
  logic [CW-1:0] wd_eff;
  logic [1:0]    reason_n;
  logic [BW:0]   sum;

  // A same-edge day_clr resets the counter before the limit check.
  assign wd_eff = day_clr ? '0 : wd_count;
  assign sum    = {1'b0, balance} + {1'b0, UNIT_W};

  always_comb begin
    state_n  = IDLE;
    bal_n    = balance;
    wd_n     = wd_eff;
    reason_n = reason;
    if (state == IDLE) begin
      if (count_down) begin
        if (balance < UNIT_W) begin
          state_n  = DENY;
          reason_n = R_FUNDS;
        end else if (wd_eff >= MAX_WD_W) begin
          state_n  = DENY;
          reason_n = R_LIMIT;
        end else begin
          state_n  = DEBIT;
          bal_n    = balance - UNIT_W;
          wd_n     = wd_eff + 1'b1;
          reason_n = R_NONE;
        end
      end else if (count_up) begin
        if (sum > MAX_W) begin
          state_n  = DENY;
          reason_n = R_CEIL;
        end else begin
          state_n  = CREDIT;
          bal_n    = sum[BW-1:0];
          reason_n = R_NONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= IDLE;
      balance  <= INIT_W;
      wd_count <= '0;
      reason   <= R_NONE;
    end else begin
      state    <= state_n;
      balance  <= bal_n;
      wd_count <= wd_n;
      reason   <= reason_n;
    end
  end

  assign done   = (state == DEBIT) || (state == CREDIT);
  assign denied = (state == DENY);
  assign busy   = (state != IDLE);

endmodule
